// File: rtl/rot_sq_pkg.sv
// Shared constants and the position-to-digit mapping for the rotating-square animation.
package rot_sq_pkg;

  localparam logic [7:0] SEG_TOP   = 8'h9C;
  localparam logic [7:0] SEG_BOT   = 8'hA3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         NUM_POS   = 8;

  typedef struct packed {
    logic [1:0] digit;
    logic [7:0] code;
  } digit_map_t;

  // Upper half walks digits 3..0 (left to right), lower half walks 0..3 back.
  function automatic digit_map_t pos_map(input logic [2:0] p);
    digit_map_t m;
    if (!p[2]) begin
      m.digit = 2'd3 - p[1:0];
      m.code  = SEG_TOP;
    end else begin
      m.digit = p[1:0];
      m.code  = SEG_BOT;
    end
    return m;
  endfunction

endpackage

// File: rtl/rot_square_ctrl_disp_mux4.sv
// Four-digit time-multiplexer: free-running refresh counter, digit select, registered an/sseg.
module disp_mux4 #(
  parameter int REFRESH_BITS = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0][7:0] codes,
  output logic [3:0]      an,
  output logic [7:0]      sseg
);
  import rot_sq_pkg::*;

  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              sel;

  assign sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  // Outputs sample the pre-edge counter, so they trail cnt by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      an   <= 4'b1111;
      sseg <= SEG_BLANK;
    end else begin
      cnt  <= cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an   <= ~(4'b0001 << sel);
      sseg <= codes[sel];
    end
  end

endmodule

// File: rtl/rot_square_ctrl.sv
// Rotating-square controller: 8-position loop stepped by tick, shown on a 4-digit display.
module rot_square_ctrl #(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       en,
  input  logic       cw,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic [2:0] pos
);
  import rot_sq_pkg::*;

  digit_map_t      pmap;
  logic [3:0][7:0] codes;

  // tick is a level qualifier, not an edge: a held tick steps once per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= 3'd0;
    end else if (tick && en) begin
      pos <= cw ? pos + 3'd1 : pos - 3'd1;
    end
  end

  assign pmap = pos_map(pos);

  always_comb begin
    codes = {4{SEG_BLANK}};
    for (int d = 0; d < 4; d++) begin
      if (pmap.digit == 2'(d)) codes[d] = pmap.code;
    end
  end

  disp_mux4 #(.REFRESH_BITS(REFRESH_BITS)) u_disp (
    .clk   (clk),
    .reset (reset),
    .codes (codes),
    .an    (an),
    .sseg  (sseg)
  );

endmodule
